// File: rtl/regwrite_arbiter.sv
// Register-file write-back arbiter: two 2-entry source FIFOs (ALU, load) feeding one registered write port.
// Define WB_RR_EN for round-robin arbitration; otherwise load has fixed priority over ALU.

module regwrite_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        not_empty,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data
);

  logic [4:0]  rd_q   [2];
  logic [31:0] data_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign ready     = (count != 2'd2);
  assign not_empty = (count != 2'd0);
  assign do_push   = push && ready;
  assign do_pop    = pop && not_empty;
  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      rd_q[0]   <= 5'd0;
      rd_q[1]   <= 5'd0;
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
    end else begin
      if (do_push) begin
        rd_q[wr_ptr]   <= push_rd;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module regwrite_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        wb_enable,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_rd_data,
  output logic        busy
);

  logic        alu_push;
  logic        ld_push;
  logic        alu_ne;
  logic        ld_ne;
  logic [4:0]  alu_head_rd;
  logic [31:0] alu_head_data;
  logic [4:0]  ld_head_rd;
  logic [31:0] ld_head_data;
  logic        grant_alu;
  logic        grant_ld;

  // Writes to x0 complete the handshake but never enter the queue.
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);

  regwrite_fifo u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (grant_alu),
    .ready     (alu_ready),
    .not_empty (alu_ne),
    .head_rd   (alu_head_rd),
    .head_data (alu_head_data)
  );

  regwrite_fifo u_ld_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_push),
    .push_rd   (ld_rd),
    .push_data (ld_data),
    .pop       (grant_ld),
    .ready     (ld_ready),
    .not_empty (ld_ne),
    .head_rd   (ld_head_rd),
    .head_data (ld_head_data)
  );

`ifdef WB_RR_EN
  logic last_ld;

  always_comb begin
    grant_ld  = 1'b0;
    grant_alu = 1'b0;
    if (ld_ne && alu_ne) begin
      grant_alu = last_ld;
      grant_ld  = !last_ld;
    end else begin
      grant_ld  = ld_ne;
      grant_alu = alu_ne;
    end
  end

  // Resets to "load last granted" so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ld <= 1'b1;
    end else if (grant_ld) begin
      last_ld <= 1'b1;
    end else if (grant_alu) begin
      last_ld <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_ld  = ld_ne;
    grant_alu = alu_ne && !ld_ne;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_enable  <= 1'b0;
      wb_rd      <= 5'd0;
      wb_rd_data <= 32'd0;
    end else if (grant_ld) begin
      wb_enable  <= 1'b1;
      wb_rd      <= ld_head_rd;
      wb_rd_data <= ld_head_data;
    end else if (grant_alu) begin
      wb_enable  <= 1'b1;
      wb_rd      <= alu_head_rd;
      wb_rd_data <= alu_head_data;
    end else begin
      wb_enable  <= 1'b0;
      wb_rd      <= 5'd0;
      wb_rd_data <= 32'd0;
    end
  end

  assign busy = alu_ne || ld_ne || wb_enable;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed vectors push expected writes, a negedge monitor checks them.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];

  regwrite_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .wb_enable  (wb_enable),
    .wb_rd      (wb_rd),
    .wb_rd_data (wb_rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected {rd,data}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_enable === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", wb_rd, wb_rd_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_rd, wb_rd_data} !== e) begin
          n_fail++;
          $display("FAIL wb_write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                   wb_rd, wb_rd_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc >= 30) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d writes pending, busy=%0b expected 0 pending, busy=0",
               name, exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_rd_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ALU write and its latency.
    exp_q.push_back({5'd5, 32'h0000_00AA});
    drive(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    idle_inputs();
    chk("lat_after_E", {31'd0, wb_enable}, 32'd0);
    @(negedge clk);
    chk("lat_after_E1", {31'd0, wb_enable}, 32'd1);
    @(negedge clk);
    chk("single_pulse", {31'd0, wb_enable}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // rd=0 load is accepted and dropped.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("rd0_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("rd0_no_write", {31'd0, wb_enable}, 32'd0);
      @(negedge clk);
      idle_inputs();
    end

    // Three back-to-back loads, written in consecutive cycles.
    exp_q.push_back({5'd1, 32'h101});
    exp_q.push_back({5'd2, 32'h102});
    exp_q.push_back({5'd3, 32'h103});
    for (int k = 1; k <= 3; k++) begin
      chk("burst_ld_ready", {31'd0, ld_ready}, 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'h100 + 32'(k));
      @(negedge clk);
      if (k > 1) chk("burst_rd", {27'd0, wb_rd}, 32'(k - 1));
    end
    idle_inputs();
    @(negedge clk);
    chk("burst_rd", {27'd0, wb_rd}, 32'd3);
    wait_drain("burst");

    // Backpressure: the losing source fills to two entries.
    do_reset();
    @(negedge clk);
`ifdef WB_RR_EN
    exp_q.push_back({5'd7, 32'h77});
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd8, 32'h88});
    exp_q.push_back({5'd2, 32'h12});
`else
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h12});
    exp_q.push_back({5'd7, 32'h77});
    exp_q.push_back({5'd8, 32'h88});
`endif
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd1, 32'h11);
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd2, 32'h12);
    @(negedge clk);
    idle_inputs();
`ifdef WB_RR_EN
    chk("bp_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("bp_alu_ready", {31'd0, alu_ready}, 32'd1);
`else
    chk("bp_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("bp_ld_ready", {31'd0, ld_ready}, 32'd1);
`endif
    wait_drain("backpressure");

    // Collision: ALU 10,11 against load 20,21.
    do_reset();
    @(negedge clk);
`ifdef WB_RR_EN
    exp_q.push_back({5'd10, 32'hA0});
    exp_q.push_back({5'd20, 32'hB0});
    exp_q.push_back({5'd11, 32'hA1});
    exp_q.push_back({5'd21, 32'hB1});
`else
    exp_q.push_back({5'd20, 32'hB0});
    exp_q.push_back({5'd21, 32'hB1});
    exp_q.push_back({5'd10, 32'hA0});
    exp_q.push_back({5'd11, 32'hA1});
`endif
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd20, 32'hB0);
    @(negedge clk);
    drive(1'b1, 5'd11, 32'hA1, 1'b1, 5'd21, 32'hB1);
    @(negedge clk);
    idle_inputs();
    wait_drain("collision");

    // Reset mid-operation discards everything queued.
    @(negedge clk);
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd22, 32'hD0);
    exp_q.push_back({5'd22, 32'hD0});
    @(negedge clk);
    drive(1'b1, 5'd13, 32'hC1, 1'b1, 5'd23, 32'hD1);
    exp_q.push_back({5'd23, 32'hD1});
    @(negedge clk);
    idle_inputs();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("midrst_wb_data", wb_rd_data, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_write", {31'd0, wb_enable}, 32'd0);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- alu_valid  in  1  ALU result request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU FIFO can accept a request
- ld_valid  in  1  load result request
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- ld_ready  out  1  load FIFO can accept a request
- wb_enable  out  1  regfile write strobe, registered
- wb_rd  out  5  regfile write address, registered
- wb_rd_data  out  32  regfile write data, registered
- busy  out  1  either FIFO non-empty or wb_enable high
REQ-002 SHALL use one clock (clk) with an asynchronous, active-low reset (rst_n).

Function
REQ-003 SHALL hold one 2-entry FIFO per source (ALU, load), each storing {rd, data}.
REQ-004 A source handshake SHALL complete at a rising edge where valid=1 and ready=1.
REQ-005 ready SHALL be 1 exactly when that FIFO holds fewer than 2 entries; it SHALL NOT depend combinationally on valid or on grant.
REQ-006 A handshake with rd=0 SHALL be accepted and discarded: no enqueue, and no regfile write results.
REQ-007 At each rising edge, the arbiter SHALL grant at most one non-empty FIFO head, pop it, and load {1, rd, data} into the output registers.
REQ-008 With no grant at an edge, wb_enable SHALL become 0; wb_rd and wb_rd_data SHALL become 0.
REQ-009 A FIFO SHALL support push and pop at the same edge, including when it holds 1 entry; its count is then unchanged.
REQ-010 Latency: an entry pushed at edge E SHALL be granted no earlier than edge E+1, so wb_enable is high no earlier than the cycle after E+1; no bypass from the inputs to the outputs.
REQ-011 Entries from one source SHALL be written in acceptance order.
REQ-012 Default arbitration SHALL be fixed priority, load over ALU.
REQ-013 FIFO read and write pointers SHALL be 1 bit each and wrap from 1 to 0.
REQ-014 Each FIFO count SHALL saturate at 0 and 2 and never overflow or underflow.
REQ-015 busy SHALL be 0 only when both FIFOs are empty and wb_enable=0.

Reset
REQ-016 While rst_n=0, both FIFOs SHALL be empty and the pointers 0.
REQ-017 While rst_n=0, wb_enable, wb_rd, wb_rd_data and busy SHALL be 0, and alu_ready and ld_ready SHALL be 1.
REQ-018 Reset asserted mid-operation SHALL discard all queued entries and any pending write; no write occurs in the cycle after deassertion.
REQ-019 The round-robin pointer (REQ-021) SHALL reset to "load last granted", so ALU wins the first tie.

Configuration
REQ-020 Macro WB_RR_EN SHALL select the arbitration policy.
REQ-021 With WB_RR_EN defined, arbitration SHALL be round-robin: when both FIFOs are non-empty, grant the source not granted last; a 1-bit last-grant register updates on every grant.
REQ-022 Without WB_RR_EN, arbitration SHALL be fixed priority as in REQ-012, and no last-grant register SHALL exist.

Verification
REQ-023 Single ALU write: alu_valid=1, rd=5, data=0x0000_00AA, accepted at edge E -> wb_enable=1, wb_rd=5, wb_rd_data=0xAA in the cycle after E+1, for 1 cycle; busy then 0.
REQ-024 rd=0 drop: ld_valid=1, ld_rd=0, data=0xDEAD_BEEF -> ld_ready stays 1 and wb_enable remains 0 throughout.
REQ-025 Full/backpressure: 3 consecutive ld_valid requests (rd 1,2,3), ALU idle, FIFOs empty -> all three writes occur in order rd 1,2,3 in consecutive cycles. In a separate run with outputs observed while 2 load entries are queued and no pop possible, ld_ready=0.
REQ-026 Collision, no WB_RR_EN: both FIFOs hold 2 entries (ALU rd 10,11; load rd 20,21) -> write order 20,21,10,11.
REQ-027 Collision, WB_RR_EN defined, same preload as REQ-026 -> write order 10,20,11,21.
REQ-028 Reset mid-operation: both FIFOs full, assert rst_n=0 for 1 cycle -> all outputs 0 at once, ready=1, and no writes after release.
